hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, multi-cycle EX wait.
// Optional performance counters are built only when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl #(
   parameter int unsigned REG_AW    = 4,
   parameter int unsigned FLUSH_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic              idex_mem_read,
   input  logic [REG_AW-1:0] idex_rd,
   input  logic              branch_taken,
   input  logic              mc_start,
   input  logic              mc_done,
   output logic              stall,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic              idex_bubble,
   output logic              pc_sel,
   output logic [1:0]        state,
   output logic [15:0]       lu_cnt,
   output logic [15:0]       mc_cnt,
   output logic [15:0]       fl_cnt
);

   localparam int unsigned FCW  = 4;
   localparam int unsigned CNTW = 16;

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_FLUSH   = 2'd1,
      S_MC_WAIT = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [FCW-1:0]   r_fl;
   logic [FCW-1:0]   w_fl_nxt;
   logic             w_load_use;
   logic             w_take_br;

   assign w_load_use = idex_mem_read && (idex_rd != '0) &&
                       ((id_rs1_used && (id_rs1 == idex_rd)) ||
                        (id_rs2_used && (id_rs2 == idex_rd)));

   // A branch wins over everything, but only where it can be acted on.
   assign w_take_br = branch_taken && ((r_state == S_RUN) || (r_state == S_FLUSH));

   always_comb begin
      stall       = 1'b0;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pc_sel      = 1'b0;
      w_state_nxt = r_state;
      w_fl_nxt    = r_fl;
      if (w_take_br) begin
         pc_sel      = 1'b1;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         w_fl_nxt    = FCW'(FLUSH_CYC - 1);
         w_state_nxt = (FLUSH_CYC == 1) ? S_RUN : S_FLUSH;
      end else begin
         case (r_state)
            S_RUN: begin
               if (mc_start) begin
                  w_state_nxt = S_MC_WAIT;
               end else if (w_load_use) begin
                  stall       = 1'b1;
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
               end
            end
            S_FLUSH: begin
               ifid_flush = 1'b1;
               w_fl_nxt   = (r_fl == '0) ? '0 : (r_fl - FCW'(1));
               if (r_fl <= FCW'(1)) begin
                  w_state_nxt = S_RUN;
               end
            end
            S_MC_WAIT: begin
               if (mc_done) begin
                  w_state_nxt = S_RUN;
               end else begin
                  stall       = 1'b1;
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
               end
            end
            default: begin
               w_state_nxt = S_RUN;
               w_fl_nxt    = '0;
            end
         endcase
      end
      // Reset forces every control output low regardless of state.
      if (rst) begin
         stall       = 1'b0;
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b0;
         idex_bubble = 1'b0;
         pc_sel      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_RUN;
         r_fl    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_fl    <= w_fl_nxt;
      end
   end

   assign state = rst ? 2'd0 : 2'(r_state);

`ifdef HAZ_PERF_CNT_EN
   logic [CNTW-1:0] r_lu_cnt;
   logic [CNTW-1:0] r_mc_cnt;
   logic [CNTW-1:0] r_fl_cnt;

   // Saturating event counters; stall in RUN can only come from load-use.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lu_cnt <= '0;
         r_mc_cnt <= '0;
         r_fl_cnt <= '0;
      end else begin
         if ((r_state == S_RUN) && stall && (r_lu_cnt != '1)) r_lu_cnt <= r_lu_cnt + CNTW'(1);
         if ((r_state == S_MC_WAIT) && stall && (r_mc_cnt != '1)) r_mc_cnt <= r_mc_cnt + CNTW'(1);
         if (ifid_flush && (r_fl_cnt != '1)) r_fl_cnt <= r_fl_cnt + CNTW'(1);
      end
   end

   assign lu_cnt = rst ? '0 : r_lu_cnt;
   assign mc_cnt = rst ? '0 : r_mc_cnt;
   assign fl_cnt = rst ? '0 : r_fl_cnt;
`else
   assign lu_cnt = '0;
   assign mc_cnt = '0;
   assign fl_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (default parameters).
module tb_hazard_ctrl;

   localparam bit PERF =
`ifdef HAZ_PERF_CNT_EN
      1'b1;
`else
      1'b0;
`endif

   // {stall, pc_write, ifid_write, ifid_flush, idex_bubble, pc_sel}
   localparam logic [5:0] O_ZERO = 6'b000000;
   localparam logic [5:0] O_RUN  = 6'b011000;
   localparam logic [5:0] O_STL  = 6'b100010;
   localparam logic [5:0] O_BR   = 6'b011111;
   localparam logic [5:0] O_FL   = 6'b011100;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  id_rs1, id_rs2, idex_rd;
   logic        id_rs1_used, id_rs2_used, idex_mem_read;
   logic        branch_taken, mc_start, mc_done;
   logic        stall, pc_write, ifid_write, ifid_flush, idex_bubble, pc_sel;
   logic [1:0]  state;
   logic [15:0] lu_cnt, mc_cnt, fl_cnt;
   logic [7:0]  obs;

   int checks   = 0;
   int failures = 0;
   int e_lu = 0, e_mc = 0, e_fl = 0;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
      .branch_taken(branch_taken), .mc_start(mc_start), .mc_done(mc_done),
      .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write),
      .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pc_sel(pc_sel),
      .state(state), .lu_cnt(lu_cnt), .mc_cnt(mc_cnt), .fl_cnt(fl_cnt)
   );

   assign obs = {stall, pc_write, ifid_write, ifid_flush, idex_bubble, pc_sel, state};

   task automatic idle();
      id_rs1 = '0; id_rs2 = '0; idex_rd = '0;
      id_rs1_used = 1'b0; id_rs2_used = 1'b0; idex_mem_read = 1'b0;
      branch_taken = 1'b0; mc_start = 1'b0; mc_done = 1'b0;
   endtask

   task automatic set_lu(input logic [3:0] rd, input logic [3:0] rs1, input logic u1,
                         input logic [3:0] rs2, input logic u2);
      idex_mem_read = 1'b1; idex_rd = rd;
      id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      branch_taken = 1'b1;
      #1;
      checks++;
      if (obs !== {O_ZERO, 2'd0}) begin
         failures++; $display("FAIL reset_outputs got=%b exp=%b", obs, {O_ZERO, 2'd0});
      end
      checks++;
      if ({lu_cnt, mc_cnt, fl_cnt} !== 48'd0) begin
         failures++; $display("FAIL reset_counters got=%h exp=0", {lu_cnt, mc_cnt, fl_cnt});
      end
      tick();
      idle();
      rst = 1'b0;
      #1;
      checks++;
      if (obs !== {O_RUN, 2'd0}) begin
         failures++; $display("FAIL run_idle got=%b exp=%b", obs, {O_RUN, 2'd0});
      end
      tick();
   endtask

   task automatic test_load_use();
      set_lu(4'd5, 4'd5, 1'b1, 4'd0, 1'b0);
      #1;
      checks++;
      if (obs !== {O_STL, 2'd0}) begin
         failures++; $display("FAIL lu_rs1 got=%b exp=%b", obs, {O_STL, 2'd0});
      end
      e_lu++;
      tick();
      idle();
      #1;
      checks++;
      if (obs !== {O_RUN, 2'd0}) begin
         failures++; $display("FAIL lu_release got=%b exp=%b", obs, {O_RUN, 2'd0});
      end
      checks++;
      if (lu_cnt !== (PERF ? 16'(e_lu) : 16'd0)) begin
         failures++; $display("FAIL lu_cnt_1 got=%0d exp=%0d", lu_cnt, PERF ? e_lu : 0);
      end
      set_lu(4'd7, 4'd1, 1'b1, 4'd7, 1'b1);
      #1;
      checks++;
      if (obs !== {O_STL, 2'd0}) begin
         failures++; $display("FAIL lu_rs2 got=%b exp=%b", obs, {O_STL, 2'd0});
      end
      e_lu++;
      tick();
      idle();
   endtask

   task automatic test_no_hazard();
      set_lu(4'd0, 4'd0, 1'b1, 4'd0, 1'b1);
      #1;
      checks++;
      if (obs !== {O_RUN, 2'd0}) begin
         failures++; $display("FAIL nohaz_rd0 got=%b exp=%b", obs, {O_RUN, 2'd0});
      end
      tick();
      set_lu(4'd5, 4'd5, 1'b0, 4'd5, 1'b0);
      #1;
      checks++;
      if (obs !== {O_RUN, 2'd0}) begin
         failures++; $display("FAIL nohaz_unused got=%b exp=%b", obs, {O_RUN, 2'd0});
      end
      tick();
      set_lu(4'd5, 4'd5, 1'b1, 4'd5, 1'b1);
      idex_mem_read = 1'b0;
      #1;
      checks++;
      if (obs !== {O_RUN, 2'd0}) begin
         failures++; $display("FAIL nohaz_noload got=%b exp=%b", obs, {O_RUN, 2'd0});
      end
      tick();
      idle();
   endtask

   task automatic test_branch();
      branch_taken = 1'b1;
      #1;
      checks++;
      if (obs !== {O_BR, 2'd0}) begin
         failures++; $display("FAIL br_cycle got=%b exp=%b", obs, {O_BR, 2'd0});
      end
      tick();
      branch_taken = 1'b0;
      #1;
      checks++;
      if (obs !== {O_FL, 2'd1}) begin
         failures++; $display("FAIL br_flush got=%b exp=%b", obs, {O_FL, 2'd1});
      end
      tick();
      e_fl += 2;
      #1;
      checks++;
      if (obs !== {O_RUN, 2'd0}) begin
         failures++; $display("FAIL br_back_run got=%b exp=%b", obs, {O_RUN, 2'd0});
      end
      checks++;
      if (fl_cnt !== (PERF ? 16'(e_fl) : 16'd0)) begin
         failures++; $display("FAIL fl_cnt_2 got=%0d exp=%0d", fl_cnt, PERF ? e_fl : 0);
      end
   endtask

   task automatic test_branch_vs_load_use();
      branch_taken = 1'b1;
      set_lu(4'd3, 4'd3, 1'b1, 4'd0, 1'b0);
      #1;
      checks++;
      if (obs !== {O_BR, 2'd0}) begin
         failures++; $display("FAIL br_lu_prio got=%b exp=%b", obs, {O_BR, 2'd0});
      end
      tick();
      branch_taken = 1'b0;
      #1;
      checks++;
      if (obs !== {O_FL, 2'd1}) begin
         failures++; $display("FAIL flush_ignores_lu got=%b exp=%b", obs, {O_FL, 2'd1});
      end
      tick();
      idle();
      e_fl += 2;
      #1;
      checks++;
      if ({lu_cnt, fl_cnt} !== (PERF ? {16'(e_lu), 16'(e_fl)} : 32'd0)) begin
         failures++; $display("FAIL br_lu_cnts got=%h exp_lu=%0d exp_fl=%0d", {lu_cnt, fl_cnt},
                              PERF ? e_lu : 0, PERF ? e_fl : 0);
      end
   endtask

   task automatic test_back_to_back_branch();
      branch_taken = 1'b1;
      tick();
      #1;
      checks++;
      if (obs !== {O_BR, 2'd1}) begin
         failures++; $display("FAIL br_in_flush got=%b exp=%b", obs, {O_BR, 2'd1});
      end
      tick();
      branch_taken = 1'b0;
      #1;
      checks++;
      if (obs !== {O_FL, 2'd1}) begin
         failures++; $display("FAIL br_reload got=%b exp=%b", obs, {O_FL, 2'd1});
      end
      tick();
      e_fl += 3;
      #1;
      checks++;
      if (obs !== {O_RUN, 2'd0}) begin
         failures++; $display("FAIL br_b2b_end got=%b exp=%b", obs, {O_RUN, 2'd0});
      end
   endtask

   task automatic test_multicycle();
      mc_start = 1'b1;
      set_lu(4'd4, 4'd4, 1'b1, 4'd0, 1'b0);
      #1;
      checks++;
      if (obs !== {O_RUN, 2'd0}) begin
         failures++; $display("FAIL mc_start_cycle got=%b exp=%b", obs, {O_RUN, 2'd0});
      end
      tick();
      idle();
      for (int i = 0; i < 4; i++) begin
         branch_taken = (i == 1);
         mc_start     = (i == 2);
         #1;
         checks++;
         if (obs !== {O_STL, 2'd2}) begin
            failures++; $display("FAIL mc_wait_%0d got=%b exp=%b", i, obs, {O_STL, 2'd2});
         end
         tick();
         e_mc++;
      end
      idle();
      mc_done = 1'b1;
      #1;
      checks++;
      if (obs !== {O_RUN, 2'd2}) begin
         failures++; $display("FAIL mc_done_cycle got=%b exp=%b", obs, {O_RUN, 2'd2});
      end
      tick();
      mc_done = 1'b0;
      #1;
      checks++;
      if (obs !== {O_RUN, 2'd0}) begin
         failures++; $display("FAIL mc_back_run got=%b exp=%b", obs, {O_RUN, 2'd0});
      end
      checks++;
      if ({lu_cnt, mc_cnt} !== (PERF ? {16'(e_lu), 16'(e_mc)} : 32'd0)) begin
         failures++; $display("FAIL mc_cnts got=%h exp_lu=%0d exp_mc=%0d", {lu_cnt, mc_cnt},
                              PERF ? e_lu : 0, PERF ? e_mc : 0);
      end
   endtask

   task automatic test_reset_in_mc_wait();
      mc_start = 1'b1;
      tick();
      mc_start = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if (obs !== {O_ZERO, 2'd0}) begin
         failures++; $display("FAIL rst_in_mc got=%b exp=%b", obs, {O_ZERO, 2'd0});
      end
      tick();
      rst = 1'b0;
      e_lu = 0; e_mc = 0; e_fl = 0;
      #1;
      checks++;
      if (obs !== {O_RUN, 2'd0}) begin
         failures++; $display("FAIL after_rst got=%b exp=%b", obs, {O_RUN, 2'd0});
      end
      checks++;
      if ({lu_cnt, mc_cnt, fl_cnt} !== 48'd0) begin
         failures++; $display("FAIL after_rst_cnts got=%h exp=0", {lu_cnt, mc_cnt, fl_cnt});
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_hazard();
      test_branch();
      test_branch_vs_load_use();
      test_back_to_back_branch();
      test_multicycle();
      test_reset_in_mc_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
